fir_decimator: RTL
==================

Name: fir_decimator

Overview:
- Downstream stage of the 4-tap FIR filter.
- Consumes the filter's 16-bit unsigned output stream, sums DECIM consecutive valid samples, and rounds and right-shifts the sum. It then saturates the result to OUT_W bits and queues it in a small output FIFO with a valid/ready interface to the consumer.
- The FIR cannot stall, so the block has no input backpressure. Results that cannot be queued are dropped, counted and flagged.

Parameters:
- IN_W, 16, input sample width (matches FIR y_out).
- OUT_W, 8, output sample width.
- DECIM, 4, decimation factor. Legal range 1..16.
- SHIFT, 6, right shift applied to the group sum. Legal range 0..IN_W.
- FIFO_DEPTH, 4, output queue entries. Must be a power of 2, at least 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of datapath, FIFO and status.
- in_valid  in  1  in_data is a new sample this cycle.
- in_data  in  IN_W  unsigned sample from the FIR.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  OUT_W  head of FIFO.
- overflow  out  1  sticky: a result was dropped.
- drop_cnt  out  8  saturating count of dropped results.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst_n is asynchronous assert, synchronous deassert, active-low.
  - While rst_n=0: phase=0, acc=0, FIFO empty, out_valid=0, out_data=0, overflow=0, drop_cnt=0.
  - Reset mid-group discards the partial sum and all queued results.
- Widths and arithmetic:
  - ACC_W = IN_W + clog2(DECIM); for DECIM=1, ACC_W = IN_W.
  - All arithmetic is unsigned.
  - The rounded sum is computed in ACC_W+1 bits, so it never wraps.
- Accumulation:
  - phase counter runs 0..DECIM-1 and advances only on in_valid=1. Gaps in in_valid do not disturb it.
  - Accepted sample with phase<DECIM-1: acc <= acc + in_data; phase++.
  - Accepted sample with phase=DECIM-1:
    - sum = acc + in_data.
    - If SHIFT>0: r = (sum + 2^(SHIFT-1)) >> SHIFT. If SHIFT=0: r = sum.
    - out = (r > 2^OUT_W-1) ? 2^OUT_W-1 : r.
    - push out into the FIFO on this same edge; acc <= 0; phase <= 0.
- Latency: out_valid rises in the cycle after the edge that accepts the last sample of a group, when the FIFO was empty.
- FIFO:
  - First-in first-out; out_data presents the head entry.
  - out_data holds its last value when empty; it is 0 only after reset or clr.
  - Pop when out_valid & out_ready.
  - Push while full without a pop in the same cycle: the result is dropped, overflow <= 1, drop_cnt++ (saturates at 255).
  - Push while full with a pop in the same cycle: both succeed, no drop, count unchanged.
  - Pop from empty never occurs, because out_valid gates it.
- Clear:
  - clr=1: phase, acc, FIFO, overflow and drop_cnt are all cleared on that edge.
  - clr has priority over in_valid and out_ready. A sample or handshake in the clr cycle is ignored.
- DECIM=1: every valid sample yields one output, still through round, shift and saturate.

Decomposition:
- Shared package fir_pkg:
  - constants IN_W and OUT_W;
  - function clog2;
  - function sat_round(sum, SHIFT, OUT_W) for reuse by other post-filter stages.
- One sub-module: sync_fifo (parameters WIDTH and DEPTH). Ports: push, pop, wdata, rdata, full, empty, clr. Includes a count and a simultaneous push/pop-when-full rule.
- Top level keeps the phase counter, accumulator and drop logic.

Test Plan (all defaults):
1. Basic group: rst_n pulse, out_ready=1, samples 100, 200, 300, 400 on 4 consecutive valid cycles. Required: sum 1000, (1000+32)>>6 = 16. out_data=16 with out_valid=1 for exactly 1 cycle, 1 cycle after the 4th sample.
2. Rounding boundary: four samples of 8 give out_data=1 (64>>6). Four samples of 7 give out_data=0 (60>>6). Valid gaps of 3 idle cycles inside a group give the same results.
3. Saturation: four samples of 5000 give sum 20000, r=313, out_data=255. Four samples of 65535 give out_data=255 with no wrap.
4. Backpressure and drop: out_ready=0, then 5 groups with results 1, 2, 3, 4, 5. Required: the 5th is dropped, overflow=1, drop_cnt=1. Then out_ready=1 yields 1, 2, 3, 4 in order, after which out_valid=0 and overflow stays 1.
5. Full with simultaneous pop and push: FIFO holds 4 entries, and out_ready=1 in the same cycle as a 5th push. Required: no drop, drop_cnt unchanged, all 5 results emerge in order.
6. Clear and reset mid-operation:
   - 2 samples of 1000, then clr, then four samples of 64: out_data=4 ((256+32)>>6), and overflow and drop_cnt are 0.
   - rst_n=0 asserted between clock edges with the FIFO non-empty: out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and helpers for the FIR post-filter stages.
package fir_pkg;

  localparam int IN_W  = 16;
  localparam int OUT_W = 8;

  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Round-half-up right shift, then clamp to the largest out_w-bit value.
  // One extra bit keeps the rounding add from wrapping.
  function automatic logic [31:0] sat_round(input logic [31:0] sum,
                                            input int          shift,
                                            input int          out_w);
    logic [32:0] r;
    logic [32:0] max_val;
    r = {1'b0, sum};
    if (shift > 0) begin
      r = (r + (33'd1 << (shift - 1))) >> shift;
    end
    max_val = (33'd1 << out_w) - 33'd1;
    if (r > max_val) begin
      r = max_val;
    end
    return r[31:0];
  endfunction

endpackage

// File: rtl/fir_decimator_if.sv
// Sample input and result output bus of the FIR decimator.
interface fir_decimator_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
);
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/fir_decimator_sync_fifo.sv
// Small synchronous FIFO with a registered head; a push while full only
// succeeds when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  import fir_pkg::*;

  localparam int PTR_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_rdata;

  logic             w_do_push;
  logic             w_do_pop;
  logic [PTR_W-1:0] w_rd_next;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_pop  = pop & ~empty & ~clr;
  assign w_do_push = push & (~full | w_do_pop) & ~clr;
  assign w_rd_next = r_rd_ptr + PTR_W'(1);
  assign rdata     = r_rdata;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // The head register holds its value when the queue drains; it only loads
  // the incoming word when that word becomes the new head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (clr) begin
      r_rdata <= '0;
    end else if (w_do_push && (empty || (w_do_pop && r_count == CNT_W'(1)))) begin
      r_rdata <= wdata;
    end else if (w_do_pop && r_count > CNT_W'(1)) begin
      r_rdata <= r_mem[w_rd_next];
    end
  end

endmodule

// File: rtl/fir_decimator.sv
// Sums DECIM valid FIR samples, rounds/shifts/saturates the sum and queues
// the result; results that find the queue full are dropped and counted.
module fir_decimator #(
  parameter int IN_W       = fir_pkg::IN_W,
  parameter int OUT_W      = fir_pkg::OUT_W,
  parameter int DECIM      = 4,
  parameter int SHIFT      = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  fir_decimator_if.slave    bus,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);
  import fir_pkg::*;

  localparam int ACC_W = IN_W + clog2(DECIM);
  localparam int PH_W  = (DECIM > 1) ? clog2(DECIM) : 1;
  localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(DECIM - 1);

  logic [PH_W-1:0]  r_phase;
  logic [ACC_W-1:0] r_acc;
  logic             r_overflow;
  logic [7:0]       r_drop_cnt;

  logic             w_last;
  logic             w_group_done;
  logic             w_pop;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic [ACC_W-1:0] w_sum;
  logic [OUT_W-1:0] w_result;
  logic [OUT_W-1:0] w_rdata;

  assign w_last       = (r_phase == LAST_PHASE);
  assign w_sum        = r_acc + ACC_W'(bus.in_data);
  assign w_result     = OUT_W'(sat_round(32'(w_sum), SHIFT, OUT_W));
  assign w_group_done = bus.in_valid & w_last & ~clr;
  assign w_pop        = ~w_empty & bus.out_ready & ~clr;
  assign w_drop       = w_group_done & w_full & ~w_pop;

  assign bus.out_valid = ~w_empty;
  assign bus.out_data  = w_rdata;
  assign overflow      = r_overflow;
  assign drop_cnt      = r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
      r_acc   <= '0;
    end else if (clr) begin
      r_phase <= '0;
      r_acc   <= '0;
    end else if (bus.in_valid) begin
      if (w_last) begin
        r_phase <= '0;
        r_acc   <= '0;
      end else begin
        r_phase <= r_phase + PH_W'(1);
        r_acc   <= w_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clr) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (w_group_done),
    .pop   (w_pop),
    .wdata (w_result),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty)
  );

endmodule
